// File: rtl/mod_7seg_scan.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// It feeds one shared decoder, inserts dead time between digits and only swaps in new data between frames.
module mod_7seg_scan #(
  parameter int DIGITS     = 4,
  parameter int ON_TICKS   = 1000,
  parameter int DEAD_TICKS = 2,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic                  i_load,
  output logic                  o_ack,
  output logic [3:0]            o_value,
  output logic [DIGITS-1:0]     o_anode_n,
  output logic                  o_frame
);

  localparam int MAX_TICKS = (ON_TICKS > DEAD_TICKS) ? ON_TICKS : DEAD_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam int IW        = $clog2(DIGITS);

  localparam logic [TW-1:0]     ON_LAST   = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]     DEAD_LAST = TW'(DEAD_TICKS - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIGIT0    = DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    ON
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [TW-1:0]       tick;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] pend;
  logic                pend_flag;
  logic                ack_pipe;

  logic                wrap;
  logic                commit;
  logic [4*DIGITS-1:0] shadow_next;
  logic [IW-1:0]       idx_adv;
  logic [DIGITS-1:0]   blank;

  function automatic logic [3:0] nibble(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] k);
    return v[4*int'(k) +: 4];
  endfunction

  // Commit is evaluated before the register update so the first digit of a
  // new frame already picks up the freshly committed value.
  always_comb begin
    wrap        = (state == ON) && i_en && (tick == ON_LAST) && (idx == IDX_LAST);
    commit      = pend_flag && ((state == IDLE) || wrap);
    shadow_next = commit ? pend : shadow;
    idx_adv     = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  // A digit is blanked when it and every more significant digit are zero.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (shadow[4*k +: 4] == 4'd0);
      blank[k] = (BLANK_LZ != 0) && zero_run;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= IDLE;
      idx       <= '0;
      tick      <= '0;
      shadow    <= '0;
      pend      <= '0;
      pend_flag <= 1'b0;
      ack_pipe  <= 1'b0;
      o_ack     <= 1'b0;
      o_value   <= '0;
      o_anode_n <= '1;
      o_frame   <= 1'b0;
    end else begin
      o_frame  <= 1'b0;
      ack_pipe <= commit;
      o_ack    <= ack_pipe;

      if (commit) begin
        shadow <= pend;
      end

      // A load that coincides with a commit stays pending for the next boundary.
      if (i_load) begin
        pend      <= i_data;
        pend_flag <= 1'b1;
      end else if (commit) begin
        pend_flag <= 1'b0;
      end

      if (!i_en) begin
        state     <= IDLE;
        idx       <= '0;
        tick      <= '0;
        o_anode_n <= '1;
      end else begin
        unique case (state)
          IDLE: begin
            state     <= DEAD;
            idx       <= '0;
            tick      <= '0;
            o_value   <= nibble(shadow_next, '0);
            o_anode_n <= '1;
          end

          DEAD: begin
            if (tick == DEAD_LAST) begin
              state     <= ON;
              tick      <= '0;
              o_anode_n <= blank[idx] ? '1 : ~(DIGIT0 << idx);
            end else begin
              tick <= tick + 1'b1;
            end
          end

          ON: begin
            if (tick == ON_LAST) begin
              state     <= DEAD;
              tick      <= '0;
              idx       <= idx_adv;
              o_value   <= nibble(shadow_next, idx_adv);
              o_anode_n <= '1;
              o_frame   <= wrap;
            end else begin
              tick <= tick + 1'b1;
            end
          end

          default: begin
            state     <= IDLE;
            idx       <= '0;
            tick      <= '0;
            o_anode_n <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_7seg_scan.sv
// Directed bench for mod_7seg_scan with DIGITS=4, ON_TICKS=4, DEAD_TICKS=2, BLANK_LZ=1.
// Frames are checked cycle by cycle against hand-derived digit/anode patterns.
module tb_mod_7seg_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] data;
  logic        load;
  logic        ack;
  logic [3:0]  value;
  logic [3:0]  anode_n;
  logic        frame;

  int checks = 0;
  int errors = 0;

  mod_7seg_scan #(
    .DIGITS    (4),
    .ON_TICKS  (4),
    .DEAD_TICKS(2),
    .BLANK_LZ  (1)
  ) dut (
    .i_clk    (clk),
    .i_nrst   (rst_n),
    .i_en     (en),
    .i_data   (data),
    .i_load   (load),
    .o_ack    (ack),
    .o_value  (value),
    .o_anode_n(anode_n),
    .o_frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples one 24-cycle frame starting at the first DEAD cycle of digit 0.
  // Up to two loads can be issued at chosen frame positions (-1 = none).
  task automatic check_frame(input string name, input logic [15:0] shown, input logic [3:0] blank,
                             input bit frame_first, input int ack_at,
                             input int la0, input logic [15:0] ld0,
                             input int la1, input logic [15:0] ld1);
    for (int k = 0; k < 24; k++) begin
      int         d;
      int         p;
      logic [3:0] one_hot;
      logic [3:0] exp_an;
      @(negedge clk);
      load    = 1'b0;
      d       = k / 6;
      p       = k % 6;
      one_hot = 4'b0001 << d;
      exp_an  = (p < 2 || blank[d]) ? 4'hF : ~one_hot;
      check($sformatf("%s k%0d anode", name, k), 32'(anode_n), 32'(exp_an));
      check($sformatf("%s k%0d value", name, k), 32'(value), 32'(shown[4*d +: 4]));
      check($sformatf("%s k%0d frame", name, k), 32'(frame), 32'(frame_first && k == 0));
      check($sformatf("%s k%0d ack", name, k), 32'(ack), 32'(k == ack_at));
      if (k == la0) begin
        load = 1'b1;
        data = ld0;
      end
      if (k == la1) begin
        load = 1'b1;
        data = ld1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    data  = 16'h0000;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset anode", 32'(anode_n), 32'hF);
    check("reset value", 32'(value), 32'h0);
    check("reset ack", 32'(ack), 32'h0);
    check("reset frame", 32'(frame), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load while idle: commit next cycle, ack one cycle after that.
    load = 1'b1;
    data = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    check("idle ack+0", 32'(ack), 32'h0);
    @(negedge clk);
    check("idle ack+1", 32'(ack), 32'h0);
    @(negedge clk);
    check("idle ack+2", 32'(ack), 32'h1);
    @(negedge clk);
    check("idle ack+3", 32'(ack), 32'h0);
    check("idle anode", 32'(anode_n), 32'hF);
    check("idle value", 32'(value), 32'h0);
    check("idle frame", 32'(frame), 32'h0);

    // Free-running scan of 1234.
    en = 1'b1;
    check_frame("f1", 16'h1234, 4'b0000, 1'b0, -1, -1, 16'h0, -1, 16'h0);
    check_frame("f2", 16'h1234, 4'b0000, 1'b1, -1, -1, 16'h0, -1, 16'h0);

    // Leading-zero blanking.
    check_frame("f3", 16'h1234, 4'b0000, 1'b1, -1, 10, 16'h0050, -1, 16'h0);
    check_frame("f4", 16'h0050, 4'b1100, 1'b1, 1, 3, 16'h0000, -1, 16'h0);

    // Two loads mid-frame: latest wins, single ack.
    check_frame("f5", 16'h0000, 4'b1110, 1'b1, 1, 5, 16'hAAAA, 10, 16'hBBBB);

    // Load sampled on the commit edge stays pending for one more frame.
    check_frame("f6", 16'hBBBB, 4'b0000, 1'b1, 1, 12, 16'h1111, 23, 16'h2222);
    check_frame("f7", 16'h1111, 4'b0000, 1'b1, 1, -1, 16'h0, -1, 16'h0);
    check_frame("f8", 16'h2222, 4'b0000, 1'b1, 1, -1, 16'h0, -1, 16'h0);

    // Drop enable during ON of digit 2.
    repeat (15) @(negedge clk);
    check("pre-drop anode", 32'(anode_n), 32'b1011);
    en = 1'b0;
    @(negedge clk);
    check("drop anode", 32'(anode_n), 32'hF);
    check("drop frame", 32'(frame), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("idle after drop anode", 32'(anode_n), 32'hF);
      check("idle after drop frame", 32'(frame), 32'h0);
    end
    en = 1'b1;
    check_frame("restart", 16'h2222, 4'b0000, 1'b0, -1, -1, 16'h0, -1, 16'h0);

    // Async reset mid-ON with pending data that must be discarded.
    repeat (3) @(negedge clk);
    check("pre-reset anode", 32'(anode_n), 32'b1110);
    load = 1'b1;
    data = 16'h5555;
    @(negedge clk);
    load = 1'b0;
    check("pre-reset anode2", 32'(anode_n), 32'b1110);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset anode", 32'(anode_n), 32'hF);
    check("async reset value", 32'(value), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post-reset ack", 32'(ack), 32'h0);
      check("post-reset anode", 32'(anode_n), 32'hF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
